// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: FSM state encodings and the sustain threshold.
// No logic and no latency.
// No flow control.
package voice_allocator_pkg;

    // Allocator control states: wait for event, walk the voices, commit the decision
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } alloc_state_t;

    // CC64 value at or above which the sustain pedal counts as pressed
    localparam int SUSTAIN_THRESH = 64;

endpackage

// File: rtl/voice_age_rank.sv
// Per-voice age ranking: rank 0 is the oldest voice, and a touched voice becomes the newest.
// Rank update lands on the clock edge of the touch, and the oldest-voice output is combinational from the rank registers.
// No flow control: a touch may be applied on any cycle.
module voice_age_rank #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               touch,
    input  logic [V_WIDTH-1:0] touch_voice,
    output logic [V_WIDTH-1:0] oldest
);

    logic [V_WIDTH-1:0] rank [VOICES];

    // Find the voice that currently holds rank 0 (ranks always form a permutation)
    always_comb begin
        oldest = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (rank[v] == '0) oldest = V_WIDTH'(v);
        end
    end

    // Promote the touched voice to newest and close the gap it leaves behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) rank[v] <= V_WIDTH'(v);
        end else if (touch) begin
            for (int v = 0; v < VOICES; v++) begin
                if (V_WIDTH'(v) == touch_voice)
                    rank[v] <= V_WIDTH'(VOICES - 1);
                else if (rank[v] > rank[touch_voice])
                    rank[v] <= rank[v] - V_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Turns note events into per-voice key state: retrigger a held key, else take the lowest free voice, else steal the oldest voice.
// Latency: event accepted on cycle 0, note_on pulses on cycle VOICES+1, and ev_ready returns on cycle VOICES+2.
// Backpressure: ev_ready is high only in IDLE, and one event is in flight at a time.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               sys_clk,
    input  logic               reset_reg,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [7:0]         ev_key,
    input  logic [7:0]         ev_vel,
    input  logic               sustain,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  keys_on,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off
);

    alloc_state_t       state;
    logic [V_WIDTH-1:0] scan_idx;
    logic [7:0]         key_q;
    logic [7:0]         vel_q;
    logic               on_q;
    logic [7:0]         key_tab [VOICES];
    logic [VOICES-1:0]  sustained;
    logic [VOICES-1:0]  vf_s1;
    logic [VOICES-1:0]  vf_s2;
    logic               sus_q;
    logic               match_hit;
    logic               free_hit;
    logic [V_WIDTH-1:0] match_v;
    logic [V_WIDTH-1:0] free_v;
    logic [V_WIDTH-1:0] steal_v;
    logic [V_WIDTH-1:0] oldest;
    logic [V_WIDTH-1:0] target;
    logic [VOICES-1:0]  free_vec;
    logic               sus_fall;
    logic               touch;

    assign free_vec = vf_s2 & ~keys_on;
    assign sus_fall = sus_q & ~sustain;
    assign touch    = (state == ISSUE) && on_q;

    // Target priority: a voice already holding the key, then the lowest free voice, then the oldest voice
    always_comb begin
        target = steal_v;
        if (match_hit)     target = match_v;
        else if (free_hit) target = free_v;
    end

    voice_age_rank #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH)
    ) u_age_rank (
        .clk         (sys_clk),
        .rst         (reset_reg),
        .touch       (touch),
        .touch_voice (target),
        .oldest      (oldest)
    );

    // Bring voice_free from the engine domain through two flops
    always_ff @(posedge sys_clk or posedge reset_reg) begin
        if (reset_reg) begin
            vf_s1 <= '0;
            vf_s2 <= '0;
        end else begin
            vf_s1 <= voice_free;
            vf_s2 <= vf_s1;
        end
    end

    // Register the pedal level so its falling edge can be detected
    always_ff @(posedge sys_clk or posedge reset_reg) begin
        if (reset_reg) sus_q <= 1'b0;
        else           sus_q <= sustain;
    end

    // Allocator FSM: accept, scan one voice per cycle, then commit the update to the key table and outputs
    always_ff @(posedge sys_clk or posedge reset_reg) begin
        if (reset_reg) begin
            state       <= IDLE;
            ev_ready    <= 1'b0;
            scan_idx    <= '0;
            key_q       <= '0;
            vel_q       <= '0;
            on_q        <= 1'b0;
            match_hit   <= 1'b0;
            free_hit    <= 1'b0;
            match_v     <= '0;
            free_v      <= '0;
            steal_v     <= '0;
            keys_on     <= '0;
            sustained   <= '0;
            note_on     <= 1'b0;
            cur_key_adr <= '0;
            cur_key_val <= '0;
            cur_vel_on  <= '0;
            cur_vel_off <= '0;
            for (int v = 0; v < VOICES; v++) key_tab[v] <= '0;
        end else begin
            note_on <= 1'b0;
            // Pedal release drops every sustained voice; the ISSUE writes below override this for their target
            if (sus_fall) begin
                keys_on   <= keys_on & ~sustained;
                sustained <= '0;
            end
            case (state)
                IDLE: begin
                    ev_ready <= 1'b1;
                    if (ev_valid && ev_ready) begin
                        ev_ready  <= 1'b0;
                        key_q     <= ev_key;
                        vel_q     <= ev_vel;
                        on_q      <= ev_on && (ev_vel != 8'd0);
                        match_hit <= 1'b0;
                        free_hit  <= 1'b0;
                        match_v   <= '0;
                        free_v    <= '0;
                        steal_v   <= '0;
                        scan_idx  <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match_hit && keys_on[scan_idx] && key_tab[scan_idx] == key_q) begin
                        match_hit <= 1'b1;
                        match_v   <= scan_idx;
                    end
                    if (!free_hit && free_vec[scan_idx]) begin
                        free_hit <= 1'b1;
                        free_v   <= scan_idx;
                    end
                    if (oldest == scan_idx) steal_v <= scan_idx;
                    if (scan_idx == V_WIDTH'(VOICES - 1)) state <= ISSUE;
                    else scan_idx <= scan_idx + V_WIDTH'(1);
                end
                ISSUE: begin
                    state <= IDLE;
                    if (on_q) begin
                        key_tab[target]   <= key_q;
                        keys_on[target]   <= 1'b1;
                        sustained[target] <= 1'b0;
                        cur_key_adr       <= target;
                        cur_key_val       <= key_q;
                        cur_vel_on        <= vel_q;
                        note_on           <= 1'b1;
                    end else if (match_hit) begin
                        cur_vel_off <= vel_q;
                        cur_key_adr <= target;
                        if (sustain) begin
                            sustained[target] <= 1'b1;
                        end else begin
                            keys_on[target]   <= 1'b0;
                            sustained[target] <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a reference model predicts each event's outcome, and a monitor compares the prediction when the event completes.
// Directed scenarios run first, followed by randomized note and sustain traffic.
// Each event is waited on with a bounded cycle budget.
module tb_voice_allocator;
    import voice_allocator_pkg::*;

    localparam int VOICES  = 8;
    localparam int V_WIDTH = 3;

    logic               sys_clk = 1'b0;
    logic               reset_reg = 1'b1;
    logic               ev_valid = 1'b0;
    logic               ev_ready;
    logic               ev_on = 1'b0;
    logic [7:0]         ev_key = '0;
    logic [7:0]         ev_vel = '0;
    logic               sustain = 1'b0;
    logic [VOICES-1:0]  voice_free = '1;
    logic [VOICES-1:0]  keys_on;
    logic               note_on;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic [7:0]         cur_vel_on;
    logic [7:0]         cur_vel_off;

    voice_allocator #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) dut (
        .sys_clk     (sys_clk),
        .reset_reg   (reset_reg),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_key      (ev_key),
        .ev_vel      (ev_vel),
        .sustain     (sustain),
        .voice_free  (voice_free),
        .keys_on     (keys_on),
        .note_on     (note_on),
        .cur_key_adr (cur_key_adr),
        .cur_key_val (cur_key_val),
        .cur_vel_on  (cur_vel_on),
        .cur_vel_off (cur_vel_off)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] keys;
        bit         note;
        logic [2:0] adr;
        logic [7:0] kval;
        logic [7:0] von;
        logic [7:0] voff;
    } exp_t;

    exp_t       sb_q[$];
    bit         m_on  [VOICES];
    bit         m_sus [VOICES];
    logic [7:0] m_key [VOICES];
    int         order[$];          // voice indices, least recently started first
    logic [2:0] m_adr;
    logic [7:0] m_kval, m_von, m_voff;
    bit         sus_level;
    logic [7:0] vf_mask = 8'hFF;

    function automatic logic [7:0] model_keys();
        logic [7:0] k;
        for (int v = 0; v < VOICES; v++) k[v] = m_on[v];
        return k;
    endfunction

    function automatic void model_reset();
        order.delete();
        for (int v = 0; v < VOICES; v++) begin
            m_on[v] = 0; m_sus[v] = 0; m_key[v] = 0;
            order.push_back(v);
        end
        m_adr = 0; m_kval = 0; m_von = 0; m_voff = 0;
        sus_level = 0;
    endfunction

    function automatic void model_event(input bit on, input logic [7:0] key, input logic [7:0] vel);
        exp_t e;
        int   m = -1;
        int   f = -1;
        int   t;
        for (int v = 0; v < VOICES; v++) begin
            if (m < 0 && m_on[v] && m_key[v] == key) m = v;
            if (f < 0 && vf_mask[v] && !m_on[v]) f = v;
        end
        e.note = 0;
        if (on && vel != 0) begin
            t = (m >= 0) ? m : (f >= 0) ? f : order[0];
            m_key[t] = key; m_on[t] = 1; m_sus[t] = 0;
            for (int i = 0; i < order.size(); i++) begin
                if (order[i] == t) begin
                    order.delete(i);
                    break;
                end
            end
            order.push_back(t);
            m_adr = 3'(t); m_kval = key; m_von = vel;
            e.note = 1;
        end else if (m >= 0) begin
            m_voff = vel; m_adr = 3'(m);
            if (sus_level) m_sus[m] = 1;
            else begin m_on[m] = 0; m_sus[m] = 0; end
        end
        e.keys = model_keys(); e.adr = m_adr; e.kval = m_kval; e.von = m_von; e.voff = m_voff;
        sb_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    bit prev_rdy  = 0;
    bit in_flight = 0;
    int cyc       = 0;
    int note_cnt  = 0;
    int note_cyc  = -1;

    // Event starts when ev_ready drops; it completes when ev_ready comes back
    always @(negedge sys_clk) begin
        exp_t e;
        if (reset_reg) begin
            in_flight = 0;
            prev_rdy  = 0;
        end else begin
            if (prev_rdy && !ev_ready) begin
                in_flight = 1; cyc = 0; note_cnt = 0; note_cyc = -1;
            end else if (in_flight) begin
                cyc++;
            end
            if (note_on) begin
                check("note_on_in_event", 32'(in_flight), 1);
                note_cnt++;
                note_cyc = cyc;
            end
            if (in_flight && !prev_rdy && ev_ready) begin
                in_flight = 0;
                if (sb_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check("ready_latency", cyc, VOICES + 2);
                    check("note_count", note_cnt, e.note ? 1 : 0);
                    if (e.note) check("note_cycle", note_cyc, VOICES + 1);
                    check("keys_on", keys_on, e.keys);
                    check("cur_key_adr", cur_key_adr, e.adr);
                    check("cur_key_val", cur_key_val, e.kval);
                    check("cur_vel_on", cur_vel_on, e.von);
                    check("cur_vel_off", cur_vel_off, e.voff);
                end
            end
            prev_rdy = ev_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_reset(input bit chk);
        @(posedge sys_clk);
        #1 reset_reg = 1'b1;
        #2;
        if (chk) begin
            check("rst_keys_on", keys_on, 0);
            check("rst_note_on", note_on, 0);
            check("rst_cur_key_adr", cur_key_adr, 0);
            check("rst_cur_key_val", cur_key_val, 0);
            check("rst_cur_vel_on", cur_vel_on, 0);
            check("rst_cur_vel_off", cur_vel_off, 0);
            check("rst_ev_ready", ev_ready, 0);
        end
        repeat (2) @(posedge sys_clk);
        #1 reset_reg = 1'b0;
        model_reset();
        if (chk) begin
            #1 check("ready_low_after_release", ev_ready, 0);
            @(posedge sys_clk);
            #1 check("ready_high_one_cycle_later", ev_ready, 1);
        end
        repeat (4) @(posedge sys_clk);
    endtask

    task automatic send(input bit on, input logic [7:0] key, input logic [7:0] vel, input bit abort);
        int w = 0;
        @(negedge sys_clk);
        while (!ev_ready && w < 40) begin
            @(negedge sys_clk);
            w++;
        end
        if (!ev_ready) begin
            check("ready_before_event", ev_ready, 1);
            return;
        end
        ev_valid = 1'b1; ev_on = on; ev_key = key; ev_vel = vel;
        @(posedge sys_clk);
        #1 ev_valid = 1'b0;
        if (abort) begin
            repeat (3) @(posedge sys_clk);
            apply_reset(1);
            check("no_note_on_after_abort", note_on, 0);
        end else begin
            model_event(on, key, vel);
            w = 0;
            @(negedge sys_clk);
            while (!ev_ready && w < 40) begin
                @(negedge sys_clk);
                w++;
            end
            if (!ev_ready) check("event_completes", ev_ready, 1);
        end
    endtask

    task automatic set_sustain(input int cc);
        bit lvl = (cc >= SUSTAIN_THRESH);
        if (sus_level && !lvl) begin
            for (int v = 0; v < VOICES; v++) begin
                if (m_sus[v]) m_on[v] = 0;
                m_sus[v] = 0;
            end
        end
        sus_level = lvl;
        sustain   = lvl;
        repeat (2) @(posedge sys_clk);
        #1 check("keys_after_pedal", keys_on, model_keys());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] k;
        logic [7:0] vl;
        model_reset();
        apply_reset(1);

        // 1: first note lands on voice 0
        send(1, 8'd60, 8'd100, 0);

        // 2: note-off releases only its voice
        send(1, 8'd62, 8'd90, 0);
        send(1, 8'd64, 8'd80, 0);
        send(0, 8'd62, 8'd40, 0);
        check("t2_keys_on", keys_on, 8'h05);

        // 3: fill all voices, then steal oldest twice
        apply_reset(0);
        for (int i = 0; i < VOICES; i++) send(1, 8'(60 + i), 8'd100, 0);
        send(1, 8'd70, 8'd110, 0);
        check("t3_steal_adr", cur_key_adr, 0);
        send(1, 8'd71, 8'd111, 0);
        check("t3_second_steal_adr", cur_key_adr, 1);

        // 4: sustain holds a released key until the pedal lifts
        apply_reset(0);
        set_sustain(127);
        send(1, 8'd60, 8'd100, 0);
        send(0, 8'd60, 8'd50, 0);
        check("t4_held_by_pedal", keys_on, 8'h01);
        set_sustain(10);
        check("t4_released", keys_on, 8'h00);

        // 5: retrigger reuses the voice; velocity 0 acts as note-off
        apply_reset(0);
        send(1, 8'd60, 8'd100, 0);
        send(1, 8'd61, 8'd100, 0);
        send(1, 8'd60, 8'd70, 0);
        check("t5_retrigger_adr", cur_key_adr, 0);
        for (int i = 0; i < VOICES - 2; i++) send(1, 8'(80 + i), 8'd60, 0);
        send(1, 8'd99, 8'd33, 0);
        check("t5_steal_skips_retriggered", cur_key_adr, 1);
        send(1, 8'd60, 8'd0, 0);

        // 6: reset during the scan aborts the event
        apply_reset(0);
        send(1, 8'd60, 8'd100, 0);
        send(1, 8'd62, 8'd90, 1);
        send(1, 8'd64, 8'd77, 0);
        check("t6_after_abort_adr", cur_key_adr, 0);

        // Randomized traffic with a fixed engine voice_free mask
        vf_mask    = 8'($urandom) | 8'h11;
        voice_free = vf_mask;
        apply_reset(0);
        repeat (120) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                set_sustain($urandom_range(0, 127));
            end else begin
                k  = ($urandom_range(0, 15) == 0) ? 8'd200 : 8'(58 + $urandom_range(0, 9));
                vl = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
                send(r < 6, k, vl, 0);
            end
        end

        repeat (20) @(posedge sys_clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
